shift_add_multiplier: RTL and testbench

Sequential unsigned multiplier, the stage directly downstream of the 8-bit ripple-carry adder. It consumes one adder instance per cycle, computing an 8x8 product over WIDTH iterations of add-and-shift. It gives the datapath a multiply without a combinational array: a start/busy/done handshake on the control side and a registered 16-bit product.

---
 rtl/shift_add_multiplier.sv | 128 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Sequential unsigned WIDTH x WIDTH multiplier. It uses one WIDTH-bit
//   ripple-carry add per cycle and a right shift of the {acc, q} partial
//   product, so it needs no combinational array multiplier.
//
//   Ports
//     clk_i      : clock, all state updates on the rising edge
//     rst_i      : synchronous active-high reset
//     start_i    : begin a multiply (sampled only while idle)
//     a_i        : multiplicand, captured on the accepted start edge
//     b_i        : multiplier, captured on the accepted start edge
//     product_o  : registered 2*WIDTH-bit result, valid from done until the
//                  next result is loaded (cleared by reset)
//     busy_o     : high whenever the engine is not idle
//     done_o     : one-cycle pulse when product_o becomes valid
module shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] product_o,
   output logic               busy_o,
   output logic               done_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   acc_q,   acc_d;
   logic [WIDTH-1:0]   q_q,     q_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     sum;       // {carry, sum}
   logic [2*WIDTH-1:0] shifted;   // next {acc, q} after one iteration

   // Ripple-carry adder: bit-serial carry chain, returns {cout, sum}.
   function automatic logic [WIDTH:0] rca_add(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             cin);
      logic [WIDTH-1:0] s;
      logic             c;
      c = cin;
      for (int i = 0; i < WIDTH; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      return {c, s};
   endfunction

   always_comb begin
      addend  = q_q[0] ? mcand_q : '0;
      sum     = rca_add(acc_q, addend, 1'b0);
      // Carry enters the MSB; the LSB of q retires each iteration.
      shifted = {sum, q_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      q_d       = q_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               mcand_d = a_i;
               q_d     = b_i;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            {acc_d, q_d} = shifted;
            cnt_d        = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               // Load the final {acc, q} on the edge entering DONE, so the
               // product is already visible during the done pulse.
               product_d = shifted;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   // Pure decodes of registered state: no input-to-output path.
   assign busy_o    = (state_q != IDLE);
   assign done_o    = (state_q == DONE);
   assign product_o = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier
//   Scoreboard bench for shift_add_multiplier: the stimulus side pushes a*b
//   for every accepted start, a monitor pops and compares on each done pulse.
module tb_shift_add_multiplier;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [7:0]  a_i;
   logic [7:0]  b_i;
   logic [15:0] product_o;
   logic        busy_o;
   logic        done_o;

   shift_add_multiplier #(.WIDTH(8)) dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .product_o(product_o),
      .busy_o   (busy_o),
      .done_o   (done_o)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          errors   = 0;
   int          n_acc    = 0;
   int          n_done   = 0;
   int          cyc      = 0;
   int          last_acc = 0;
   logic        prev_done = 1'b0;
   logic [15:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (!rst_i && done_o) begin
         n_done++;
         checks++;
         if (prev_done) begin
            errors++;
            $display("FAIL done_width: done high on consecutive cycles (t=%0t)", $time);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: product %0d with nothing outstanding (t=%0t)",
                     product_o, $time);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (product_o !== e) begin
               errors++;
               $display("FAIL product: got %0d, expected %0d (t=%0t)", product_o, e, $time);
            end
         end
      end
      prev_done = done_o;
   end

   // Waits for idle, presents a/b with start for one edge, records expectation.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit chk_iv);
      int n;
      n = 0;
      @(negedge clk);
      while (busy_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("issue_idle_wait", {31'd0, busy_o}, 32'd0);
      a_i     = a;
      b_i     = b;
      start_i = 1'b1;
      @(posedge clk);
      if (chk_iv) check("issue_interval", cyc - last_acc, 10);
      last_acc = cyc;
      exp_q.push_back(16'(a) * 16'(b));
      n_acc++;
      #1 start_i = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   initial begin
      int d0;
      rst_i   = 1'b1;
      start_i = 1'b1;
      a_i     = 8'd55;
      b_i     = 8'd66;

      // Reset with start held high
      repeat (2) begin
         @(negedge clk);
         check("rst_product", product_o, 0);
         check("rst_busy", {31'd0, busy_o}, 0);
         check("rst_done", {31'd0, done_o}, 0);
      end
      @(posedge clk);
      #1 rst_i = 1'b0;
      start_i = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("post_rst_product", product_o, 0);
         check("post_rst_busy", {31'd0, busy_o}, 0);
         check("post_rst_done", {31'd0, done_o}, 0);
      end

      // Basic multiply with cycle-exact timing
      issue(8'd13, 8'd11, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) check("basic_busy_rise", {31'd0, busy_o}, 1);
         if (k < 9)  check("basic_done_early", {31'd0, done_o}, 0);
         if (k == 9) begin
            check("basic_done", {31'd0, done_o}, 1);
            check("basic_product", product_o, 143);
         end
         if (k == 10) begin
            check("basic_busy_fall", {31'd0, busy_o}, 0);
            check("basic_done_fall", {31'd0, done_o}, 0);
         end
         if (k == 20) check("basic_hold", product_o, 143);
      end
      wait_drain();

      // Extremes
      issue(8'd255, 8'd255, 1'b0);
      issue(8'd0,   8'd200, 1'b0);
      issue(8'd1,   8'd255, 1'b0);
      issue(8'd128, 8'd2,   1'b0);
      wait_drain();

      // Start while busy, including the DONE cycle (now in cycle T+1)
      d0 = n_done;
      issue(8'd3, 8'd5, 1'b0);
      repeat (3) @(posedge clk);
      #1 a_i = 8'd7; b_i = 8'd9; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1 start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      @(negedge clk);
      check("busy_ignored_start", {31'd0, busy_o}, 0);
      repeat (15) @(negedge clk);
      check("busy_done_count", n_done - d0, 1);
      check("busy_product", product_o, 15);

      // Reset mid-operation, then recovery
      issue(8'd200, 8'd100, 1'b0);
      repeat (4) @(posedge clk);
      #1 rst_i = 1'b1;
      @(posedge clk);
      #1 rst_i = 1'b0;
      void'(exp_q.pop_back());
      n_acc--;
      d0 = n_done;
      @(negedge clk);
      check("abort_busy", {31'd0, busy_o}, 0);
      check("abort_product", product_o, 0);
      check("abort_done", {31'd0, done_o}, 0);
      repeat (12) @(negedge clk);
      check("abort_no_done", n_done - d0, 0);
      issue(8'd6, 8'd7, 1'b0);
      wait_drain();
      check("recover_product", product_o, 42);

      // Back-to-back random
      for (int i = 0; i < 1000; i++) begin
         issue(8'($urandom), 8'($urandom), i > 0);
      end
      wait_drain();
      repeat (3) @(negedge clk);
      check("done_count", n_done, n_acc);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
